// File: rtl/phys_mem_ctrl.sv
// Shared main-memory stage: word-organised RAM behind a fixed-latency FSM,
// one request in flight, one-cycle mem_ready completion pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no request latched; accepts mem_access on the next edge
// ST_WAIT | request latched; cnt counts down to the access edge
// ST_DONE | access performed; mem_ready high for this single cycle
module phys_mem_ctrl #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] mem_a,
  input  logic [31:0] mem_st_data,
  input  logic        mem_access,
  input  logic        mem_write,
  output logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        mem_busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("phys_mem_ctrl: LATENCY must lie in 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          data_q;
  logic                 write_q;
  logic                 accept;
  logic                 do_access;
  logic                 unused_addr_bits;
  logic [31:0]          ram [2**ADDR_BITS];

  // Byte offset and bits above the RAM window alias away.
  assign unused_addr_bits = ^{mem_a[31:ADDR_BITS+2], mem_a[1:0]};

  assign accept    = (state == ST_IDLE) && mem_access;
  assign do_access = (state == ST_WAIT) && (cnt == 4'd0);
  assign mem_ready = (state == ST_DONE);
  assign mem_busy  = (state != ST_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mem_access) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt      <= 4'd0;
      addr_q   <= '0;
      data_q   <= 32'h0;
      write_q  <= 1'b0;
      mem_data <= 32'h0;
    end else begin
      if (accept) begin
        addr_q  <= mem_a[ADDR_BITS+1:2];
        data_q  <= mem_st_data;
        write_q <= mem_write;
        cnt     <= CNT_LOAD;
      end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access && !write_q) begin
        mem_data <= ram[addr_q];
      end
    end
  end

  // RAM is deliberately unreset; reset still blocks writes because state is reset.
  always_ff @(posedge clock) begin
    if (do_access && write_q) begin
      ram[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Scoreboard bench for phys_mem_ctrl: driver pushes expected completions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_phys_mem_ctrl;
  localparam int AW  = 10;
  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mem_a = 32'h0;
  logic [31:0] mem_st_data = 32'h0;
  logic        mem_access = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        mem_busy;

  phys_mem_ctrl #(.ADDR_BITS(AW), .LATENCY(LAT)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .mem_a      (mem_a),
    .mem_st_data(mem_st_data),
    .mem_access (mem_access),
    .mem_write  (mem_write),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .mem_busy   (mem_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          accept_cyc;
    int          ready_cyc;
    logic        is_load;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [int];
  int          free_from = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_on = 1'b0;
  logic [31:0] cur_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << AW));
  endfunction

  // Monitor: expected outputs come only from the queue and the held load value.
  always @(negedge clock) begin
    logic exp_ready;
    logic exp_busy;
    if (mon_on) begin
      if (!resetn) cur_data = 32'h0;
      exp_ready = (q.size() > 0) && (cyc == q[0].ready_cyc);
      exp_busy  = (q.size() > 0) && (cyc >= q[0].accept_cyc) && (cyc <= q[0].ready_cyc);
      chk("mem_ready", {31'b0, mem_ready}, {31'b0, exp_ready});
      chk("mem_busy", {31'b0, mem_busy}, {31'b0, exp_busy});
      if (exp_ready) begin
        if (q[0].is_load) cur_data = q[0].data;
        void'(q.pop_front());
      end
      chk("mem_data", mem_data, cur_data);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Called 1 time unit after a posedge; returns in the cycle mem_ready is due.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic wr,
                       input bit hold, input bit scramble);
    int   acc;
    exp_t e;
    mem_a       = a;
    mem_st_data = d;
    mem_write   = wr;
    mem_access  = 1'b1;
    acc = (cyc + 1 > free_from) ? cyc + 1 : free_from;
    e.accept_cyc = acc;
    e.ready_cyc  = acc + LAT;
    e.is_load    = !wr;
    if (wr) begin
      model[widx(a)] = d;
      e.data = d;
    end else begin
      e.data = model[widx(a)];
    end
    q.push_back(e);
    free_from = acc + LAT + 2;
    while (cyc < acc + LAT) begin
      step(1);
      if (scramble && cyc == acc) begin
        mem_access  = 1'b0;
        mem_a       = $urandom;
        mem_st_data = $urandom;
        mem_write   = 1'($urandom_range(0, 1));
      end
    end
    if (!hold) mem_access = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    exp_t e;
    logic [31:0] a;
    bit wr;
    bit hold;
    bit scr;

    resetn = 1'b0;
    step(3);
    mon_on = 1'b1;
    resetn = 1'b1;
    step(10);

    // Store/load round trip, aliasing and byte offset.
    issue(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    issue(32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b0);
    step(2);
    issue(32'h0000_0004, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    issue(32'h0000_1007, 32'h0, 1'b0, 1'b0, 1'b0);

    // Inputs changing after acceptance are ignored.
    issue(32'h0000_0040, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0);
    mem_a = 32'h20; mem_st_data = 32'hA; mem_write = 1'b1; mem_access = 1'b1;
    acc = (cyc + 1 > free_from) ? cyc + 1 : free_from;
    e.accept_cyc = acc; e.ready_cyc = acc + LAT; e.is_load = 1'b0; e.data = 32'hA;
    model[widx(32'h20)] = 32'hA;
    q.push_back(e);
    free_from = acc + LAT + 2;
    while (cyc < acc) step(1);
    step(1);
    mem_access = 1'b0; mem_a = 32'h40; mem_st_data = 32'hB;
    while (cyc < acc + LAT) step(1);
    issue(32'h0000_0020, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0);

    // Arbiter-style back-to-back with mem_access held high.
    issue(32'h0000_0014, 32'hCAFE_0014, 1'b1, 1'b0, 1'b0);
    step(3);
    issue(32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(32'h0000_0014, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset two cycles into WAIT aborts the store.
    issue(32'h0000_0030, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    mem_a = 32'h30; mem_st_data = 32'hFFFF_FFFF; mem_write = 1'b1; mem_access = 1'b1;
    acc = (cyc + 1 > free_from) ? cyc + 1 : free_from;
    e.accept_cyc = acc; e.ready_cyc = acc + LAT; e.is_load = 1'b0; e.data = 32'hFFFF_FFFF;
    q.push_back(e);
    while (cyc < acc + 2) step(1);
    resetn = 1'b0;
    mem_access = 1'b0;
    q.delete();
    free_from = 0;
    step(2);
    resetn = 1'b1;
    step(1);
    issue(32'h0000_0030, 32'h0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic over a small aliased word pool.
    for (int i = 0; i < 80; i++) begin
      a = ($urandom << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wr = !model.exists(widx(a)) || ($urandom_range(0, 1) == 1);
      hold = ($urandom_range(0, 1) == 1);
      scr = !hold && ($urandom_range(0, 3) == 0);
      issue(a, $urandom, wr, hold, scr);
      if (!hold) begin
        mem_a = $urandom;
        mem_st_data = $urandom;
        step($urandom_range(0, 2));
      end
    end
    mem_access = 1'b0;
    step(LAT + 4);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
